// File: rtl/approx_add_err_monitor.sv
// approx_add_err_monitor
// Error-metric stage for approximate adders. Each accepted sample carries two
// operands and the approximate sum. Over a programmed number of samples the
// block accumulates squared error, absolute error, the maximum absolute error
// and the count of mismatching samples.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse: clear results, latch num_samples, run
//   num_samples       samples per run (0 finishes immediately)
//   in_valid/in_ready sample handshake; in_a, in_b, in_approx sample data
//   busy              high while running or draining the pipeline
//   done              one-cycle pulse when the run completes
//   sum_sq_err, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt results
//   acc_ovf           sticky flag: an accumulator saturated during this run
//   sum_err           signed error sum (only when ERR_MON_BIAS_EN is defined)
//
// Optional feature macro: ERR_MON_BIAS_EN adds the saturating signed sum_err.
module approx_add_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 20,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    input  logic [WIDTH:0]          in_approx,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        sum_sq_err,
    output logic [ACC_W-1:0]        sum_abs_err,
    output logic [WIDTH:0]          max_abs_err,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [CNT_W-1:0]        sample_cnt,
`ifdef ERR_MON_BIAS_EN
    output logic signed [ACC_W-1:0] sum_err,
`endif
    output logic                    acc_ovf
);

    // Wide enough to add either a squared error or an accumulator plus a carry.
    localparam int SQ_W = 2 * (WIDTH + 1);
    localparam int SW   = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam int EW   = ((ACC_W > WIDTH + 2) ? ACC_W : WIDTH + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         num_lat;
    logic [CNT_W-1:0]         acc_cnt;
    logic [CNT_W-1:0]         acc_cnt_inc;
    logic                     accept;
    logic                     start_go;

    logic [WIDTH:0]           exact;
    logic signed [WIDTH+1:0]  err;
    logic [WIDTH:0]           abs_c;

    logic                     s1_v;
    logic [WIDTH:0]           s1_abs;
    logic                     s1_nz;
    logic signed [WIDTH+1:0]  s1_err;
    logic                     s2_v;

    logic [SQ_W-1:0]          sq;
    logic [SW-1:0]            sq_sum;
    logic [SW-1:0]            abs_sum;
    logic [SW-1:0]            acc_max;
    logic                     sq_sat;
    logic                     abs_sat;
    logic                     e_sat;
`ifdef ERR_MON_BIAS_EN
    logic signed [EW-1:0]     e_sum;
    logic signed [EW-1:0]     e_hi;
    logic signed [EW-1:0]     e_lo;
`endif

    // Handshake and start qualification; start only acts when idle or done.
    always_comb begin
        accept      = in_valid & in_ready;
        start_go    = start & ((state == IDLE) | (state == DONE));
        acc_cnt_inc = acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Stage-1 arithmetic: exact sum, signed error and its magnitude.
    always_comb begin
        exact = {1'b0, in_a} + {1'b0, in_b};
        err   = $signed({1'b0, in_approx}) - $signed({1'b0, exact});
        // Magnitude always fits in WIDTH+1 bits, so negate only the low bits.
        if (err[WIDTH+1]) begin
            abs_c = ~err[WIDTH:0] + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            abs_c = err[WIDTH:0];
        end
    end

    // Stage-2 arithmetic: squared error and saturating accumulator sums.
    always_comb begin
        sq      = {{(WIDTH+1){1'b0}}, s1_abs} * {{(WIDTH+1){1'b0}}, s1_abs};
        acc_max = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
        sq_sum  = {{(SW-ACC_W){1'b0}}, sum_sq_err} + {{(SW-SQ_W){1'b0}}, sq};
        abs_sum = {{(SW-ACC_W){1'b0}}, sum_abs_err} + {{(SW-WIDTH-1){1'b0}}, s1_abs};
        sq_sat  = (sq_sum > acc_max);
        abs_sat = (abs_sum > acc_max);
`ifdef ERR_MON_BIAS_EN
        e_hi  = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
        e_lo  = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
        e_sum = {{(EW-ACC_W){sum_err[ACC_W-1]}}, sum_err}
              + {{(EW-WIDTH-2){s1_err[WIDTH+1]}}, s1_err};
        e_sat = (e_sum > e_hi) | (e_sum < e_lo);
`else
        e_sat = 1'b0;
`endif
    end

    // Control FSM with registered in_ready, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            num_lat  <= {CNT_W{1'b0}};
            acc_cnt  <= {CNT_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_lat <= num_samples;
                        acc_cnt <= {CNT_W{1'b0}};
                        if (num_samples == {CNT_W{1'b0}}) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt_inc;
                        if (acc_cnt_inc == num_lat) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Leave only once the last sample has reached the results.
                    if (!s1_v && !s2_v) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_abs <= {(WIDTH+1){1'b0}};
            s1_nz  <= 1'b0;
            s1_err <= {(WIDTH+2){1'b0}};
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_abs <= abs_c;
                s1_nz  <= (err != {(WIDTH+2){1'b0}});
                s1_err <= err;
            end
        end
    end

    // Stage-2 result accumulation; start clears everything for a new run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v         <= 1'b0;
            sum_sq_err   <= {ACC_W{1'b0}};
            sum_abs_err  <= {ACC_W{1'b0}};
            max_abs_err  <= {(WIDTH+1){1'b0}};
            mismatch_cnt <= {CNT_W{1'b0}};
            sample_cnt   <= {CNT_W{1'b0}};
            acc_ovf      <= 1'b0;
`ifdef ERR_MON_BIAS_EN
            sum_err      <= {ACC_W{1'b0}};
`endif
        end else if (start_go) begin
            s2_v         <= 1'b0;
            sum_sq_err   <= {ACC_W{1'b0}};
            sum_abs_err  <= {ACC_W{1'b0}};
            max_abs_err  <= {(WIDTH+1){1'b0}};
            mismatch_cnt <= {CNT_W{1'b0}};
            sample_cnt   <= {CNT_W{1'b0}};
            acc_ovf      <= 1'b0;
`ifdef ERR_MON_BIAS_EN
            sum_err      <= {ACC_W{1'b0}};
`endif
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                sum_sq_err  <= sq_sat ? {ACC_W{1'b1}} : sq_sum[ACC_W-1:0];
                sum_abs_err <= abs_sat ? {ACC_W{1'b1}} : abs_sum[ACC_W-1:0];
                if (s1_abs > max_abs_err) begin
                    max_abs_err <= s1_abs;
                end
                if (s1_nz) begin
                    mismatch_cnt <= mismatch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                sample_cnt <= sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                acc_ovf    <= acc_ovf | sq_sat | abs_sat | e_sat;
`ifdef ERR_MON_BIAS_EN
                if (e_sum > e_hi) begin
                    sum_err <= e_hi[ACC_W-1:0];
                end else if (e_sum < e_lo) begin
                    sum_err <= e_lo[ACC_W-1:0];
                end else begin
                    sum_err <= e_sum[ACC_W-1:0];
                end
`endif
            end
        end
    end

endmodule
